// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and helper function for the generic FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int C_DEFAULT_WORD_SIZE = 22;

    localparam int MODE_REG  = 0;
    localparam int MODE_FWFT = 1;

    // Bits needed to encode values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ram
// Description : DEPTH x WORD_SIZE storage, synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WORD_SIZE = C_DEFAULT_WORD_SIZE,
    parameter int DEPTH     = 20,
    parameter int AW        = clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 write_enable,
    input  logic [AW-1:0]        write_addr,
    input  logic [WORD_SIZE-1:0] write_data,
    input  logic [AW-1:0]        read_addr,
    output logic [WORD_SIZE-1:0] read_data
);

    logic [WORD_SIZE-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (write_enable) begin
            r_mem[write_addr] <= write_data;
        end
    end

    assign read_data = r_mem[read_addr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_gen.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_gen
// Description : Parametrised synchronous FIFO, registered or FWFT read data.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_gen
    import fifo_pkg::*;
#(
    parameter int WORD_SIZE = C_DEFAULT_WORD_SIZE,
    parameter int DEPTH     = 20,
    parameter int FWFT      = MODE_REG,
    parameter int AF_MARGIN = 2,
    parameter int AE_MARGIN = 2,
    parameter int CW        = clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write_enable,
    input  logic                 read_enable,
    input  logic                 flush,
    input  logic                 clear_errors,
    input  logic [WORD_SIZE-1:0] data_in,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 empty_signal,
    output logic                 full_signal,
    output logic                 almost_empty,
    output logic                 almost_full,
    output logic [CW-1:0]        count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int             c_AW       = clog2(DEPTH);
    localparam logic [c_AW-1:0] c_LAST_PTR = c_AW'(DEPTH - 1);
    localparam int             c_AF_LEVEL = DEPTH - AF_MARGIN;
    localparam logic           c_AF_RESET = (AF_MARGIN >= DEPTH);

    logic [c_AW-1:0]      r_head;
    logic [c_AW-1:0]      r_tail;
    logic [CW-1:0]        r_count;
    logic                 r_empty;
    logic                 r_full;
    logic                 r_almost_empty;
    logic                 r_almost_full;
    logic                 r_overflow;
    logic                 r_underflow;
    logic [WORD_SIZE-1:0] r_data_out;

    logic                 w_rd_ok;
    logic                 w_wr_ok;
    logic                 w_push;
    logic                 w_pop;
    logic [c_AW-1:0]      w_head_next;
    logic [c_AW-1:0]      w_tail_next;
    logic [CW-1:0]        w_count_next;
    logic [WORD_SIZE-1:0] w_ram_rdata;

    function automatic logic [c_AW-1:0] next_ptr(input logic [c_AW-1:0] ptr);
        return (ptr == c_LAST_PTR) ? '0 : ptr + c_AW'(1);
    endfunction

    // Full-with-read is accepted as a pass-through; flush suppresses both sides.
    assign w_rd_ok = read_enable & ~r_empty;
    assign w_wr_ok = write_enable & (~r_full | w_rd_ok);
    assign w_push  = w_wr_ok & ~flush;
    assign w_pop   = w_rd_ok & ~flush;

    always_comb begin
        w_head_next  = r_head;
        w_tail_next  = r_tail;
        w_count_next = r_count;
        if (flush) begin
            w_head_next  = '0;
            w_tail_next  = '0;
            w_count_next = '0;
        end else begin
            if (w_push) begin
                w_head_next = next_ptr(r_head);
            end
            if (w_pop) begin
                w_tail_next = next_ptr(r_tail);
            end
            if (w_push && !w_pop) begin
                w_count_next = r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                w_count_next = r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= c_AF_RESET;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
            r_data_out     <= '0;
        end else begin
            r_head         <= w_head_next;
            r_tail         <= w_tail_next;
            r_count        <= w_count_next;
            r_empty        <= (w_count_next == '0);
            r_full         <= (w_count_next == CW'(DEPTH));
            r_almost_empty <= (int'(w_count_next) <= AE_MARGIN);
            r_almost_full  <= (int'(w_count_next) >= c_AF_LEVEL);
            r_overflow     <= (write_enable & ~w_wr_ok & ~flush) | (r_overflow & ~clear_errors);
            r_underflow    <= (read_enable & r_empty & ~flush) | (r_underflow & ~clear_errors);
            if ((FWFT == MODE_REG) && w_pop) begin
                r_data_out <= w_ram_rdata;
            end
        end
    end

    fifo_ram #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH),
        .AW        (c_AW)
    ) u_fifo_ram (
        .clk          (clk),
        .write_enable (w_push),
        .write_addr   (r_head),
        .write_data   (data_in),
        .read_addr    (r_tail),
        .read_data    (w_ram_rdata)
    );

    generate
        if (FWFT == MODE_FWFT) begin : g_fwft
            assign data_out = r_empty ? '0 : w_ram_rdata;
        end else begin : g_reg
            assign data_out = r_data_out;
        end
    endgenerate

    assign empty_signal = r_empty;
    assign full_signal  = r_full;
    assign almost_empty = r_almost_empty;
    assign almost_full  = r_almost_full;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire
